// File: rtl/bubble_sort_ctrl.sv
// Sequential bubble-sort accelerator: loads N words, sorts them ascending with one
// compare-and-swap per clock, then streams the sorted words out.
module bubble_sort_ctrl #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 8,
  parameter int unsigned IDX_W = 3,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             sort_busy,
  output logic [CNT_W-1:0] swap_count
);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_PASS = IDX_W'(N - 2);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SORT  = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [W-1:0]     mem_q [N];
  logic [W-1:0]     mem_d [N];
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0] cmp_idx_q, cmp_idx_d;
  logic [IDX_W-1:0] pass_q, pass_d;
  logic             swapped_q, swapped_d;
  logic [CNT_W-1:0] swap_count_q, swap_count_d;

  logic [IDX_W-1:0] cmp_nxt;
  logic [W-1:0]     left_w;
  logic [W-1:0]     right_w;
  logic             load_accept;
  logic             load_last;
  logic             do_swap;
  logic             pass_end;
  logic             sort_done;
  logic             drain_accept;
  logic             drain_last;

  // Compare/swap datapath decode
  always_comb begin
    cmp_nxt      = cmp_idx_q + IDX_ONE;
    left_w       = mem_q[cmp_idx_q];
    right_w      = mem_q[cmp_nxt];
    load_accept  = (state_q == S_LOAD) && in_valid;
    load_last    = load_accept && (wr_idx_q == LAST_IDX);
    do_swap      = (state_q == S_SORT) && (left_w > right_w);
    pass_end     = (cmp_idx_q == (LAST_PASS - pass_q));
    // Early exit uses the swap flag including this cycle's compare
    sort_done    = (state_q == S_SORT) && pass_end &&
                   ((pass_q == LAST_PASS) || !(swapped_q || do_swap));
    drain_accept = (state_q == S_DRAIN) && out_ready;
    drain_last   = drain_accept && (rd_idx_q == LAST_IDX);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LOAD:  if (load_last)  state_d = S_SORT;
      S_SORT:  if (sort_done)  state_d = S_DRAIN;
      S_DRAIN: if (drain_last) state_d = S_LOAD;
      default: state_d = S_LOAD;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    sort_busy  = 1'b0;
    out_data   = '0;
    swap_count = swap_count_q;
    unique case (state_q)
      S_LOAD:  in_ready  = 1'b1;
      S_SORT:  sort_busy = 1'b1;
      S_DRAIN: begin
        out_valid = 1'b1;
        out_data  = mem_q[rd_idx_q];
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Index, pass and counter next values
  always_comb begin
    wr_idx_d     = wr_idx_q;
    rd_idx_d     = rd_idx_q;
    cmp_idx_d    = cmp_idx_q;
    pass_d       = pass_q;
    swapped_d    = swapped_q;
    swap_count_d = swap_count_q;

    if (load_accept) begin
      wr_idx_d = wr_idx_q + IDX_ONE;
    end
    if (load_last) begin
      wr_idx_d     = '0;
      pass_d       = '0;
      cmp_idx_d    = '0;
      swapped_d    = 1'b0;
      swap_count_d = '0;
    end

    if (do_swap) begin
      swapped_d = 1'b1;
      if (swap_count_q != '1) begin
        swap_count_d = swap_count_q + CNT_ONE;
      end
    end

    if (state_q == S_SORT) begin
      if (!pass_end) begin
        cmp_idx_d = cmp_nxt;
      end else if (sort_done) begin
        rd_idx_d = '0;
      end else begin
        pass_d    = pass_q + IDX_ONE;
        cmp_idx_d = '0;
        swapped_d = 1'b0;
      end
    end

    if (drain_accept) begin
      rd_idx_d = drain_last ? '0 : (rd_idx_q + IDX_ONE);
    end
  end

  // Array next value: load write or in-place swap
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      mem_d[i] = mem_q[i];
    end
    if (load_accept) begin
      mem_d[wr_idx_q] = in_data;
    end
    if (do_swap) begin
      mem_d[cmp_idx_q] = right_w;
      mem_d[cmp_nxt]   = left_w;
    end
  end

  // Control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_idx_q     <= '0;
      rd_idx_q     <= '0;
      cmp_idx_q    <= '0;
      pass_q       <= '0;
      swapped_q    <= 1'b0;
      swap_count_q <= '0;
    end else begin
      wr_idx_q     <= wr_idx_d;
      rd_idx_q     <= rd_idx_d;
      cmp_idx_q    <= cmp_idx_d;
      pass_q       <= pass_d;
      swapped_q    <= swapped_d;
      swap_count_q <= swap_count_d;
    end
  end

  // Array storage is not reset; contents are don't-care until loaded
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(N); i++) begin
      mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: tb/tb_bubble_sort_ctrl.sv
// Directed bench for bubble_sort_ctrl: a value-level model (ranks, inversion count,
// pass count) predicts sorted order, swap_count and SORT duration for each job.
module tb_bubble_sort_ctrl;

  localparam int N = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        sort_busy;
  logic [15:0] swap_count;

  int checks   = 0;
  int failures = 0;
  bit inv_en   = 1'b0;
  int pat[4]   = '{1, 0, 0, 1};

  bubble_sort_ctrl #(.W(8), .N(8), .IDX_W(3), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .sort_busy  (sort_busy),
    .swap_count (swap_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Sorted order by rank, swaps = inversion count, passes = 1 + max larger-to-the-left
  task automatic model(input int a[N], output int s[N], output int swaps, output int cyc);
    int maxl;
    int passes;
    swaps = 0;
    maxl  = 0;
    for (int i = 0; i < N; i++) begin
      int pos;
      int left_big;
      pos = 0;
      left_big = 0;
      for (int j = 0; j < N; j++) begin
        if (a[j] < a[i] || (a[j] == a[i] && j < i)) pos++;
        if (j < i && a[j] > a[i]) left_big++;
      end
      s[pos] = a[i];
      swaps += left_big;
      if (left_big > maxl) maxl = left_big;
    end
    passes = (maxl + 1 > N - 1) ? N - 1 : maxl + 1;
    cyc = 0;
    for (int p = 0; p < passes; p++) cyc += N - 1 - p;
  endtask

  // Per-cycle invariants: exactly one phase indicator, out_data zero when idle
  always @(negedge clk) begin
    if (inv_en) begin
      chk("phase_onehot", int'(in_ready) + int'(out_valid) + int'(sort_busy), 1);
      if (!out_valid) chk("out_data_idle", out_data, 0);
    end
  end

  // Enters and leaves at a negedge; rst_at>0 aborts with reset on that SORT cycle
  task automatic run_job(input int a[N], input bit stall, input bit poke, input int rst_at);
    int s[N];
    int swaps;
    int cyc;
    int busy;
    int k;
    int t;
    bit prev_stall;
    logic [7:0] held;
    model(a, s, swaps, cyc);
    for (int i = 0; i < N; i++) begin
      chk("load_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 8'(a[i]);
      @(negedge clk);
    end
    in_valid = poke;
    in_data  = poke ? 8'hAA : 8'h00;
    busy = 0;
    while (sort_busy === 1'b1 && busy < 200) begin
      if (busy == 0) chk("swcnt_clear_at_sort", swap_count, 0);
      chk("sort_in_ready", in_ready, 0);
      busy++;
      if (busy == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", sort_busy, 0);
        chk("rst_swcnt", swap_count, 0);
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_data  = 8'h00;
    chk("sort_cycles", busy, cyc);
    chk("swap_count", swap_count, swaps);
    k = 0;
    t = 0;
    prev_stall = 1'b0;
    held = 8'h00;
    while (k < N && t < 200) begin
      bit rdy;
      chk("drain_valid", out_valid, 1);
      chk("drain_data", out_data, s[k]);
      if (prev_stall) chk("drain_hold", out_data, held);
      rdy = stall ? pat[t % 4][0] : 1'b1;
      out_ready  = rdy;
      held       = out_data;
      prev_stall = !rdy;
      @(negedge clk);
      if (rdy) k++;
      t++;
    end
    out_ready = 1'b0;
    chk("handshakes", k, N);
    chk("next_in_ready", in_ready, 1);
    chk("post_out_valid", out_valid, 0);
    chk("swcnt_hold", swap_count, swaps);
  endtask

  initial begin
    int rev[N];
    int asc[N];
    int mix[N];
    int pr[N];
    int s[N];
    int sw;
    int cy;
    int mix_sorted[N];

    rev = '{8, 7, 6, 5, 4, 3, 2, 1};
    asc = '{1, 2, 3, 4, 5, 6, 7, 8};
    mix = '{3, 1, 3, 0, 255, 1, 0, 2};
    pr  = '{2, 1, 4, 3, 6, 5, 8, 7};
    mix_sorted = '{0, 0, 1, 1, 2, 3, 3, 255};

    // Hand-computed pins on the model
    model(rev, s, sw, cy);
    chk("model_rev_swaps", sw, 28);
    chk("model_rev_cycles", cy, 28);
    chk("model_rev_first", s[0], 1);
    chk("model_rev_last", s[7], 8);
    model(asc, s, sw, cy);
    chk("model_asc_swaps", sw, 0);
    chk("model_asc_cycles", cy, 7);
    model(pr, s, sw, cy);
    chk("model_pair_swaps", sw, 4);
    chk("model_pair_cycles", cy, 13);
    model(mix, s, sw, cy);
    chk("model_mix_swaps", sw, 15);
    for (int i = 0; i < N; i++) chk("model_mix_order", s[i], mix_sorted[i]);

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_sort_busy", sort_busy, 0);
    chk("rst_swap_count", swap_count, 0);
    reset  = 1'b0;
    inv_en = 1'b1;

    run_job(rev, 1'b0, 1'b0, 0);
    run_job(asc, 1'b0, 1'b1, 0);
    run_job(mix, 1'b1, 1'b0, 0);
    run_job(mix, 1'b0, 1'b0, 10);
    run_job(pr,  1'b0, 1'b0, 0);
    run_job(rev, 1'b1, 1'b1, 0);

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
